// File: rtl/usrt_pkg.sv
// Shared constants and FSM encoding for the USRT transmitter.
package usrt_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam int unsigned FRAME_LEN   = 10;  // start + 8 data + stop
  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned IDLE_BITS   = 1;   // guard bit sent in ST_GAP
  localparam int unsigned CLK_DIV_DEF = 8;
endpackage

// File: rtl/usrt_trans_if.sv
// Byte-write handshake plus serial outputs of the USRT transmitter.
interface usrt_trans_if;
  logic       wr;
  logic [7:0] din;
  logic       ready;
  logic       busy;
  logic       usrt_clk;
  logic       tx;

  modport master (output wr, din, input ready, busy, usrt_clk, tx);
  modport slave  (input wr, din, output ready, busy, usrt_clk, tx);
endinterface

// File: rtl/usrt_clkgen.sv
// Free-running serial clock divider; rise_o marks the clk cycle ending in a 0->1 edge.
module usrt_clkgen
  import usrt_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic usrt_clk_o,
  output logic rise_o
);
  logic [7:0] div_q, div_d;
  logic       uclk_q, uclk_d;
  logic       wrap;

  assign wrap = (div_q == 8'(CLK_DIV - 1));

  always_comb begin
    div_d  = wrap ? 8'd0 : div_q + 8'd1;
    uclk_d = wrap ? ~uclk_q : uclk_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      uclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      uclk_q <= uclk_d;
    end
  end

  assign usrt_clk_o = uclk_q;
  assign rise_o     = wrap & ~uclk_q;
endmodule

// File: rtl/usrt_trans.sv
// USRT transmitter: 10-bit frames plus one guard bit, tx updated on usrt_clk rise.
// Define USRT_TRANS_BUF_EN for a one-byte holding register that allows back-to-back frames.
module usrt_trans
  import usrt_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic         clk,
  input  logic         rst,
  usrt_trans_if.slave  bus
);
  state_e     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       tx_q, tx_d;
  logic       uclk, rise, accept, ready, pend, load;
  logic [7:0] pdata;

  usrt_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .usrt_clk_o(uclk),
    .rise_o    (rise)
  );

`ifdef USRT_TRANS_BUF_EN
  logic [7:0] hold_q, hold_d;
  logic       hvld_q, hvld_d;
  assign ready = ~hvld_q;
  assign pend  = hvld_q;
  assign pdata = hold_q;
`else
  // The shifter itself holds the accepted byte until START.
  logic pend_q, pend_d;
  assign ready = (state_q == ST_IDLE) & ~pend_q;
  assign pend  = pend_q;
  assign pdata = sh_q;
`endif

  assign accept = bus.wr & ready;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    load    = 1'b0;
`ifdef USRT_TRANS_BUF_EN
    hold_d = hold_q;
    hvld_d = hvld_q;
    if (accept) begin
      hold_d = bus.din;
      hvld_d = 1'b1;
    end
`else
    pend_d = pend_q;
    if (accept) begin
      sh_d   = bus.din;
      pend_d = 1'b1;
    end
`endif
    if (rise) begin
      unique case (state_q)
        ST_IDLE:  if (pend) load = 1'b1;
        ST_START: begin
          state_d = ST_DATA;
          tx_d    = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
          bit_d   = '0;
        end
        ST_DATA: begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
          end
        end
        ST_STOP: begin
          state_d = ST_GAP;
          tx_d    = 1'b1;
        end
        ST_GAP: begin
          if (pend) load = 1'b1;
          else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
    if (load) begin
      state_d = ST_START;
      tx_d    = 1'b0;
      sh_d    = pdata;
`ifdef USRT_TRANS_BUF_EN
      hvld_d  = 1'b0;
`else
      pend_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
`ifdef USRT_TRANS_BUF_EN
      hold_q  <= '0;
      hvld_q  <= 1'b0;
`else
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
`ifdef USRT_TRANS_BUF_EN
      hold_q  <= hold_d;
      hvld_q  <= hvld_d;
`else
      pend_q  <= pend_d;
`endif
    end
  end

  assign bus.ready    = ready;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.usrt_clk = uclk;
  assign bus.tx       = tx_q;
endmodule

// File: tb/tb_usrt_trans.sv
// Directed bench for usrt_trans: frame table plus latency, overlap and reset sequences.
module tb_usrt_trans;
  localparam int CD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usrt_trans_if bus();
  usrt_trans #(.CLK_DIV(CD)) dut (.clk(clk), .rst(rst), .bus(bus));

  // bits: tx sampled at successive usrt_clk falling edges, first bit in [10]
  typedef struct {
    logic [7:0]  din;
    logic [10:0] bits;
  } vec_t;
  vec_t vecs[4];

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ufall(output bit ok);
    logic prev;
    ok   = 1'b0;
    prev = bus.usrt_clk;
    for (int i = 0; i < 4 * CD + 4; i++) begin
      @(negedge clk);
      if (prev && !bus.usrt_clk) begin
        ok = 1'b1;
        break;
      end
      prev = bus.usrt_clk;
    end
    if (!ok) chk("usrt_clk_timeout", 0, 1);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 200; i++) begin
      if (bus.busy) break;
      @(negedge clk);
    end
    if (!bus.busy) chk("busy_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] d);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("ready_timeout", 0, 1);
    bus.wr  = 1'b1;
    bus.din = d;
    @(negedge clk);
    bus.wr  = 1'b0;
  endtask

  task automatic capture(output logic [10:0] b, output int nb);
    bit ok;
    b  = '1;
    nb = 0;
    wait_busy();
    for (int i = 0; i < 11; i++) begin
      wait_ufall(ok);
      b[10-i] = bus.tx;
      if (bus.busy) nb++;
    end
  endtask

  logic [10:0] b, b2;
  int          nb, cnt;
  bit          ok;
  logic        prev;

  initial begin
    vecs[0] = '{8'hA5, 11'b01010010111};
    vecs[1] = '{8'h00, 11'b00000000011};
    vecs[2] = '{8'hFF, 11'b01111111111};
    vecs[3] = '{8'h5A, 11'b00101101011};

    rst = 1'b1; bus.wr = 1'b0; bus.din = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", bus.tx, 1);
    chk("rst_uclk", bus.usrt_clk, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.ready, 1);
    rst = 1'b0;

    // usrt_clk period in clk cycles
    wait_ufall(ok);
    prev = bus.usrt_clk;
    cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (prev && !bus.usrt_clk) break;
      prev = bus.usrt_clk;
    end
    chk("uclk_period", cnt, 2 * CD);

    for (int v = 0; v < 4; v++) begin
      send(vecs[v].din);
      capture(b, nb);
      chk($sformatf("frame_%02h", vecs[v].din), b, vecs[v].bits);
      chk($sformatf("busy_bits_%02h", vecs[v].din), nb, 11);
      wait_ufall(ok);
      chk($sformatf("idle_busy_%02h", vecs[v].din), bus.busy, 0);
      chk($sformatf("idle_tx_%02h", vecs[v].din), bus.tx, 1);
    end

    // wr coincident with the rise strobe in IDLE: start bit one period later
    wait_ufall(ok);
    repeat (CD - 1) @(negedge clk);
    bus.wr = 1'b1; bus.din = 8'hA5;
    @(negedge clk);
    bus.wr = 1'b0;
    wait_ufall(ok);
    chk("coinc_not_started_busy", bus.busy, 0);
    chk("coinc_not_started_tx", bus.tx, 1);
    wait_ufall(ok);
    chk("coinc_start_busy", bus.busy, 1);
    chk("coinc_start_tx", bus.tx, 0);
    for (int i = 0; i < 11; i++) wait_ufall(ok);
    chk("coinc_end_busy", bus.busy, 0);

`ifdef USRT_TRANS_BUF_EN
    send(8'h11);
    wait_busy();
    chk("buf_ready_in_frame", bus.ready, 1);
    bus.wr = 1'b1; bus.din = 8'h22;
    @(negedge clk);
    bus.wr = 1'b0;
    chk("buf_full_ready", bus.ready, 0);
    capture(b, nb);
    capture(b2, nb);
    chk("buf_frame_11", b, 11'b01000100011);
    chk("buf_frame_22", b2, 11'b00100010011);
    wait_ufall(ok);
    chk("buf_end_busy", bus.busy, 0);
`else
    send(8'h3C);
    wait_busy();
    chk("nobuf_ready_in_frame", bus.ready, 0);
    bus.wr = 1'b1; bus.din = 8'hC3;
    @(negedge clk);
    bus.wr = 1'b0;
    capture(b, nb);
    chk("nobuf_frame_3c", b, 11'b00011110011);
    wait_ufall(ok);
    wait_ufall(ok);
    wait_ufall(ok);
    chk("nobuf_no_second_frame", bus.busy, 0);
    chk("nobuf_ready_idle", bus.ready, 1);
`endif

    // reset in the middle of a frame while tx is driving a 0 data bit
    send(8'h5A);
    wait_busy();
    for (int i = 0; i < 6; i++) wait_ufall(ok);
    repeat (CD) @(negedge clk);
    chk("pre_rst_tx", bus.tx, 0);
    rst = 1'b1;
    #1;
    chk("midrst_tx", bus.tx, 1);
    chk("midrst_uclk", bus.usrt_clk, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(8'h5A);
    capture(b, nb);
    chk("post_rst_frame_5a", b, 11'b00101101011);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/usrt_trans.md
USRT_TRANS -- requirements
Module: usrt_trans

Interface
REQ-001 Parameter CLK_DIV, default 8: clk cycles per usrt_clk half-period; legal range 2..255.
REQ-002 Port clk, input, 1: single system clock; all logic clocked on its rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port wr, input, 1: write strobe; data accepted on a clk edge where wr=1 and ready=1.
REQ-005 Port din, input, 8: byte to transmit, sampled on acceptance.
REQ-006 Port ready, output, 1: block can accept a byte this cycle.
REQ-007 Port busy, output, 1: a frame is in progress (START..GAP).
REQ-008 Port usrt_clk, output, 1: free-running serial bit clock for the USRT receiver.
REQ-009 Port tx, output, 1: serial data line, idle high.

Function
REQ-010 SHALL toggle usrt_clk every CLK_DIV clk cycles, continuously, independent of frame activity; period is 2*CLK_DIV.
REQ-011 SHALL change tx only in the clk cycle in which usrt_clk goes 0->1, so tx is stable at every falling edge, where the receiver samples.
REQ-012 SHALL send each frame as 10 bits: start 0, din[0]..din[7] LSB first, stop 1, followed by one idle bit (tx=1) in state GAP.
REQ-013 SHALL implement FSM IDLE->START->DATA(8 bits, 3-bit counter)->STOP->GAP->IDLE; every transition occurs on a usrt_clk rising strobe only.
REQ-014 SHALL drive the start bit at the first usrt_clk rising edge after acceptance; worst-case latency is 2*CLK_DIV clk cycles.
REQ-015 SHALL leave GAP for START directly, skipping IDLE, when a byte is pending; otherwise it returns to IDLE.
REQ-016 SHALL assert busy in START, DATA, STOP and GAP, and deassert it in IDLE.
REQ-017 Without the buffer, ready=1 only in IDLE; wr while ready=0 SHALL be ignored, with no state change and no data corruption.
REQ-018 SHALL keep tx=1 in IDLE.

Reset
REQ-019 On rst, SHALL asynchronously set: state=IDLE, tx=1, usrt_clk=0, divider=0, bit counter=0, busy=0, ready=1, buffer empty.
REQ-020 rst mid-frame SHALL abort the frame immediately, and tx SHALL return to 1 in the same cycle; no partial frame resumes after reset.

Configuration
REQ-021 Macro USRT_TRANS_BUF_EN SHALL add a one-byte holding register.
REQ-022 With USRT_TRANS_BUF_EN defined:
  - ready=1 whenever the holding register is empty;
  - a byte accepted during a frame is sent immediately after that frame's GAP bit;
  - the holding register frees when its byte is loaded into the shifter.
REQ-023 Without USRT_TRANS_BUF_EN, no holding register exists and REQ-017 applies.

Structure
REQ-024 Shared package usrt_pkg SHALL hold:
  - FSM state encodings;
  - frame length (10);
  - CLK_DIV default;
  - idle-bit count (1).
REQ-025 Sub-module usrt_clkgen SHALL implement the divider and output usrt_clk plus a one-cycle rise strobe; the FSM and shifter stay in usrt_trans.

Verification
REQ-026 CLK_DIV=4, wr with din=0xA5 -> tx at successive usrt_clk rising edges = 0,1,0,1,0,0,1,0,1,1, then 1 (GAP); busy high for exactly 11 bit periods.
REQ-027 Loopback into usrt_rec, din=0x00 then 0xFF -> receiver rdy pulses once per frame, with data 0x00 then 0xFF.
REQ-028 No buffer: wr 0x3C accepted, then wr 0xC3 mid-frame -> 0xC3 ignored, only 0x3C transmitted, ready=0 until IDLE.
REQ-029 USRT_TRANS_BUF_EN: wr 0x11, then wr 0x22 mid-frame -> two frames with exactly one idle bit between them, receiver yields 0x11 then 0x22.
REQ-030 rst asserted during bit 4 of a frame -> tx=1 and usrt_clk=0 in the same cycle; next frame 0x5A after reset is received correctly.
REQ-031 wr at the clk cycle coincident with a usrt_clk rising strobe in IDLE -> start bit appears at the next rising edge, not the current one.
